// File: rtl/panel_tx.sv
// Serialises one device word per frame onto a two-device 595 chain, alternating
// device 1 (phase 0) and device 2 (phase 1) with a latch pulse and hold between frames.
module panel_tx #(
  parameter int WIDTH    = 32,
  parameter int CLK_DIV  = 1,
  parameter int HOLD_CYC = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] rA,
  input  logic [WIDTH-1:0] rB,
  output logic             ds,
  output logic             shcp,
  output logic             stcp,
  output logic             oe,
  output logic             phase,
  output logic             busy,
  output logic             frame_done
);

  localparam int N  = 2 * WIDTH;
  localparam int BW = $clog2(N);
  localparam int DW = $clog2(CLK_DIV) + 1;
  localparam int HW = $clog2(HOLD_CYC) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH, HOLD} state_t;

  state_t           state, next_state;
  logic [BW-1:0]    bit_cnt;
  logic [BW-1:0]    bit_idx;
  logic [DW-1:0]    div_cnt;
  logic [HW-1:0]    hold_cnt;
  logic             half;
  logic [WIDTH-1:0] shadow_a, shadow_b, pend_a, pend_b;
  logic             pend_vld;
  logic             oe_r, phase_r, done_r;
  logic [N-1:0]     frame;
  logic             div_end, hold_end, last_bit;

  assign div_end  = (div_cnt == DW'(CLK_DIV - 1));
  assign hold_end = (hold_cnt == HW'(HOLD_CYC - 1));
  assign last_bit = (bit_cnt == BW'(N - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (load) next_state = SHIFT;
      SHIFT:   if (div_end && half && last_bit) next_state = LATCH;
      LATCH:   if (div_end) next_state = HOLD;
      HOLD:    if (hold_end) next_state = SHIFT;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt  <= '0;
      div_cnt  <= '0;
      hold_cnt <= '0;
      half     <= 1'b0;
      shadow_a <= '0;
      shadow_b <= '0;
      pend_a   <= '0;
      pend_b   <= '0;
      pend_vld <= 1'b0;
      oe_r     <= 1'b1;
      phase_r  <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (load && state != IDLE) begin
        pend_a   <= rA;
        pend_b   <= rB;
        pend_vld <= 1'b1;
      end
      case (state)
        IDLE: if (load) begin
          shadow_a <= rA;
          shadow_b <= rB;
          phase_r  <= 1'b0;
          bit_cnt  <= '0;
          div_cnt  <= '0;
          half     <= 1'b0;
        end
        SHIFT: begin
          if (div_end) begin
            div_cnt <= '0;
            half    <= ~half;
            if (half && !last_bit) bit_cnt <= bit_cnt + 1'b1;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        LATCH: begin
          if (div_end) begin
            div_cnt  <= '0;
            hold_cnt <= '0;
            done_r   <= 1'b1;
            oe_r     <= 1'b0;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        HOLD: begin
          if (hold_end) begin
            phase_r <= ~phase_r;
            bit_cnt <= '0;
            div_cnt <= '0;
            half    <= 1'b0;
            // New words only take effect at the start of a phase-0 frame; a same-cycle load beats pending data.
            if (phase_r) begin
              if (load) begin
                shadow_a <= rA;
                shadow_b <= rB;
                pend_vld <= 1'b0;
              end else if (pend_vld) begin
                shadow_a <= pend_a;
                shadow_b <= pend_b;
                pend_vld <= 1'b0;
              end
            end
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign frame   = phase_r ? {shadow_b, {WIDTH{1'b0}}} : {{WIDTH{1'b0}}, shadow_a};
  assign bit_idx = BW'(N - 1) - bit_cnt;

  assign ds         = (state == SHIFT) && frame[bit_idx];
  assign shcp       = (state == SHIFT) && half;
  assign stcp       = (state == LATCH);
  assign oe         = oe_r;
  assign phase      = phase_r;
  assign busy       = (state != IDLE);
  assign frame_done = done_r;

endmodule
